// File: rtl/xadac_stage_vload_pkg.sv
// Shared types for the xadac vector-load stage: ID/address/vector widths,
// scoreboard entry states and byte-enable helpers.
package xadac_stage_vload_pkg;
  localparam int IdWidth  = 2;
  localparam int NumIds   = 1 << IdWidth;
  localparam int VecBytes = 16;
  localparam int XLen     = 32;

  typedef logic [IdWidth-1:0]    IdT;
  typedef logic [XLen-1:0]       AddrT;
  typedef logic [XLen-1:0]       RegT;
  typedef logic [VecBytes-1:0]   BeT;
  typedef logic [VecBytes*8-1:0] VectorT;
  typedef logic [XLen-1:0]       ImmT;

  typedef enum logic [1:0] {FREE, PEND, WAIT, DONE} vload_state_e;

  // imm counts bytes from byte 0; anything past the vector saturates to all ones
  function automatic BeT imm_to_be(ImmT imm);
    BeT be;
    be = '0;
    for (int i = 0; i < VecBytes; i++) be[i] = (ImmT'(i) < imm);
    return be;
  endfunction

  function automatic VectorT mask_bytes(VectorT d, BeT be);
    VectorT m;
    m = '0;
    for (int i = 0; i < VecBytes; i++) m[i*8 +: 8] = be[i] ? d[i*8 +: 8] : 8'h00;
    return m;
  endfunction
endpackage

// File: rtl/xadac_stage_vload_if.sv
// xadac dispatcher request/response channel and the OBI data-memory port
// used by the vector-load stage.
interface xadac_if;
  import xadac_stage_vload_pkg::*;
  logic   req_valid;
  logic   req_ready;
  IdT     req_id;
  RegT    req_rs1;
  RegT    req_rs2;
  VectorT req_vs3;
  ImmT    req_imm;
  logic   resp_valid;
  logic   resp_ready;
  IdT     resp_id;
  RegT    resp_rd;
  VectorT resp_vd;

  modport mst (output req_valid, req_id, req_rs1, req_rs2, req_vs3, req_imm, resp_ready,
               input  req_ready, resp_valid, resp_id, resp_rd, resp_vd);
  modport slv (input  req_valid, req_id, req_rs1, req_rs2, req_vs3, req_imm, resp_ready,
               output req_ready, resp_valid, resp_id, resp_rd, resp_vd);
endinterface

interface xadac_obi_if;
  import xadac_stage_vload_pkg::*;
  logic   req;
  logic   gnt;
  AddrT   addr;
  logic   we;
  BeT     be;
  VectorT wdata;
  IdT     aid;
  logic   rvalid;
  logic   rready;
  VectorT rdata;
  IdT     rid;

  modport mst (output req, addr, we, be, wdata, aid, rready,
               input  gnt, rvalid, rdata, rid);
  modport slv (input  req, addr, we, be, wdata, aid, rready,
               output gnt, rvalid, rdata, rid);
endinterface

// File: rtl/xadac_prio_pick.sv
// Lowest-index picker: flags whether any request bit is set and returns
// the index of the lowest one.
module xadac_prio_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IW'(i);
    end
  end
endmodule

// File: rtl/xadac_stage_vload.sv
// Vector-load stage: per-ID scoreboard that issues one OBI read per xadac
// request, captures the returned vector and responds out of order.
module xadac_stage_vload
  import xadac_stage_vload_pkg::*;
#(
  parameter bit MaskBytes = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  xadac_if.slv     slv,
  xadac_obi_if.mst obi
);
  vload_state_e r_state [NumIds];
  AddrT         r_addr  [NumIds];
  BeT           r_be    [NumIds];
  VectorT       r_data  [NumIds];

  vload_state_e w_state_n [NumIds];
  AddrT         w_addr_n  [NumIds];
  BeT           w_be_n    [NumIds];
  VectorT       w_data_n  [NumIds];

  logic [NumIds-1:0] w_pend, w_done;
  logic   w_iss_vld, w_rsp_vld, w_req_ready, w_resp_hs;
  IdT     w_iss_idx, w_rsp_idx;

  logic   r_req;
  AddrT   r_obi_addr;
  BeT     r_obi_be;
  IdT     r_aid;
  logic   r_resp_valid;
  IdT     r_resp_id;
  VectorT r_resp_vd;

  // Next scoreboard: the four events touch entries in distinct states, so
  // they can all land in one cycle; the response frees before the accept.
  always_comb begin
    w_state_n = r_state;
    w_addr_n  = r_addr;
    w_be_n    = r_be;
    w_data_n  = r_data;
    w_pend    = '0;
    w_done    = '0;
    w_resp_hs = r_resp_valid && slv.resp_ready;
    if (w_resp_hs) w_state_n[r_resp_id] = FREE;
    if (r_req && obi.gnt) w_state_n[r_aid] = WAIT;
    if (obi.rvalid && r_state[obi.rid] == WAIT) begin
      w_state_n[obi.rid] = DONE;
      w_data_n[obi.rid]  = MaskBytes ? mask_bytes(obi.rdata, r_be[obi.rid]) : obi.rdata;
    end
    w_req_ready = slv.req_valid && (w_state_n[slv.req_id] == FREE);
    if (w_req_ready) begin
      w_state_n[slv.req_id] = PEND;
      w_addr_n[slv.req_id]  = AddrT'(slv.req_rs1);
      w_be_n[slv.req_id]    = imm_to_be(slv.req_imm);
    end
    for (int i = 0; i < NumIds; i++) begin
      w_pend[i] = (w_state_n[i] == PEND);
      w_done[i] = (w_state_n[i] == DONE);
    end
  end

  xadac_prio_pick #(.N(NumIds)) u_iss_pick (.i_req(w_pend), .o_valid(w_iss_vld), .o_idx(w_iss_idx));
  xadac_prio_pick #(.N(NumIds)) u_rsp_pick (.i_req(w_done), .o_valid(w_rsp_vld), .o_idx(w_rsp_idx));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumIds; i++) begin
        r_state[i] <= FREE;
        r_addr[i]  <= '0;
        r_be[i]    <= '0;
        r_data[i]  <= '0;
      end
      r_req        <= 1'b0;
      r_obi_addr   <= '0;
      r_obi_be     <= '0;
      r_aid        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_vd    <= '0;
    end else begin
      r_state <= w_state_n;
      r_addr  <= w_addr_n;
      r_be    <= w_be_n;
      r_data  <= w_data_n;
      // Picking from the next state lets a grant hand straight over to the next PEND.
      if (!(r_req && !obi.gnt)) begin
        r_req <= w_iss_vld;
        if (w_iss_vld) begin
          r_aid      <= w_iss_idx;
          r_obi_addr <= w_addr_n[w_iss_idx];
          r_obi_be   <= w_be_n[w_iss_idx];
        end
      end
      if (!(r_resp_valid && !slv.resp_ready)) begin
        r_resp_valid <= w_rsp_vld;
        if (w_rsp_vld) begin
          r_resp_id <= w_rsp_idx;
          r_resp_vd <= w_data_n[w_rsp_idx];
        end
      end
    end
  end

  assign obi.req        = r_req;
  assign obi.addr       = r_obi_addr;
  assign obi.be         = r_obi_be;
  assign obi.aid        = r_aid;
  assign obi.we         = 1'b0;
  assign obi.wdata      = '0;
  assign obi.rready     = 1'b1;
  assign slv.req_ready  = w_req_ready;
  assign slv.resp_valid = r_resp_valid;
  assign slv.resp_id    = r_resp_id;
  assign slv.resp_vd    = r_resp_vd;
  assign slv.resp_rd    = '0;

  // Stray R beats (e.g. arriving after a reset) are dropped, but flagged.
  always @(posedge clk) begin
    if (!rst && obi.rvalid)
      assert (r_state[obi.rid] == WAIT)
        else $warning("xadac_stage_vload: rvalid for non-waiting rid %0d dropped", obi.rid);
  end
endmodule

// File: tb/tb_xadac_stage_vload.sv
// Bench for xadac_stage_vload: directed scenarios, then randomized traffic
// checked against a per-ID transaction model.
module tb_xadac_stage_vload;
  import xadac_stage_vload_pkg::*;

  localparam int M_FREE = 0, M_PEND = 1, M_WAIT = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  xadac_if     s_if ();
  xadac_obi_if o_if ();

  xadac_stage_vload #(.MaskBytes(1'b1)) dut (.clk(clk), .rst(rst), .slv(s_if), .obi(o_if));

  // model: what each ID should be doing, in plain transaction terms
  int     m_st   [NumIds];
  AddrT   m_addr [NumIds];
  ImmT    m_imm  [NumIds];
  VectorT m_data [NumIds];

  AddrT   a2 [3];
  ImmT    i2 [3];
  VectorT d2 [3];
  int     ord [3];
  AddrT   aa, ab;
  ImmT    ia;
  VectorT v1, da, db;
  bit     p_a_stall, p_r_stall, a_hs, r_hs, exp_rdy, rv_on;
  IdT     h_aid, h_rid, rv_id;
  AddrT   h_addr;
  BeT     h_be;
  VectorT h_vd, rv_d;
  int     nw, sel, n_resp, busy;

  function automatic BeT exp_be(ImmT imm);
    logic [31:0] e;
    e = (imm >= VecBytes) ? 32'h0000_FFFF : (32'd1 << imm) - 32'd1;
    return e[VecBytes-1:0];
  endfunction

  function automatic VectorT exp_vd(VectorT d, ImmT imm);
    VectorT keep;
    if (imm >= VecBytes) return d;
    keep = (VectorT'(1) << (imm * 8)) - VectorT'(1);
    return d & keep;
  endfunction

  function automatic int lowest(int want);
    for (int i = 0; i < NumIds; i++) if (m_st[i] == want) return i;
    return -1;
  endfunction

  function automatic VectorT rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv_req(input logic v, input IdT id, input AddrT a, input ImmT imm);
    s_if.req_valid = v;
    s_if.req_id    = id;
    s_if.req_rs1   = a;
    s_if.req_imm   = imm;
    s_if.req_rs2   = $urandom;
    s_if.req_vs3   = rnd_vec();
  endtask

  task automatic drv_r(input logic v, input IdT id, input VectorT d);
    o_if.rvalid = v;
    o_if.rid    = id;
    o_if.rdata  = d;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    drv_req(0, 0, 0, 0);
    drv_r(0, 0, '0);
    o_if.gnt = 1'b0;
    s_if.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
    chk("rst_req", o_if.req, 0);
    chk("rst_addr", o_if.addr, 0);
    chk("rst_be", o_if.be, 0);
    chk("rst_aid", o_if.aid, 0);
    chk("rst_resp_valid", s_if.resp_valid, 0);
    chk("rst_resp_id", s_if.resp_id, 0);
    chk("rst_resp_vd", s_if.resp_vd, 0);
    chk("rst_rready", o_if.rready, 1);
    tick();

    // single load, minimal latency
    o_if.gnt = 1'b1;
    s_if.resp_ready = 1'b1;
    v1 = 128'h0123_4567_89AB_CDEF_DEAD_BEEF_CAFE_F00D;
    drv_req(1, 2, 32'h100, 4); settle();
    chk("t1_ready", s_if.req_ready, 1);
    tick();
    drv_req(0, 0, 0, 0); settle();
    chk("t1_req", o_if.req, 1);
    chk("t1_addr", o_if.addr, 32'h100);
    chk("t1_be", o_if.be, 16'h000F);
    chk("t1_aid", o_if.aid, 2);
    chk("t1_we", o_if.we, 0);
    chk("t1_wdata", o_if.wdata, 0);
    tick();
    drv_r(1, 2, v1); settle();
    chk("t1_no_early_resp", s_if.resp_valid, 0);
    tick();
    drv_r(0, 0, '0); settle();
    chk("t1_resp_valid", s_if.resp_valid, 1);
    chk("t1_resp_id", s_if.resp_id, 2);
    chk("t1_resp_vd", s_if.resp_vd, 128'hCAFE_F00D);
    chk("t1_resp_rd", s_if.resp_rd, 0);
    tick(); settle();
    chk("t1_resp_gone", s_if.resp_valid, 0);
    tick();

    // back-to-back issue, out-of-order return 2,0,1
    ord = '{2, 0, 1};
    for (int k = 0; k < 3; k++) begin
      a2[k] = $urandom;
      i2[k] = $urandom_range(1, 16);
      d2[k] = rnd_vec();
    end
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drv_req(1, IdT'(k), a2[k], i2[k]);
      else drv_req(0, 0, 0, 0);
      settle();
      if (k > 0) begin
        chk("t2_req", o_if.req, 1);
        chk("t2_aid", o_if.aid, k - 1);
        chk("t2_addr", o_if.addr, a2[k-1]);
        chk("t2_be", o_if.be, exp_be(i2[k-1]));
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drv_r(1, IdT'(ord[k]), d2[ord[k]]);
      else drv_r(0, 0, '0);
      settle();
      if (k == 0) chk("t2_idle", o_if.req, 0);
      else begin
        chk("t2_resp_valid", s_if.resp_valid, 1);
        chk("t2_resp_id", s_if.resp_id, ord[k-1]);
        chk("t2_resp_vd", s_if.resp_vd, exp_vd(d2[ord[k-1]], i2[ord[k-1]]));
      end
      tick();
    end
    settle();
    chk("t2_resp_gone", s_if.resp_valid, 0);
    tick();

    // backpressure on gnt and resp_ready; imm 20 saturates, imm 0 empties
    o_if.gnt = 1'b0;
    aa = $urandom; ab = $urandom; da = rnd_vec(); db = rnd_vec();
    drv_req(1, 1, aa, 20); settle(); tick();
    drv_req(1, 0, ab, 0); settle();
    chk("t3_first_aid", o_if.aid, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drv_req(0, 0, 0, 0); settle();
      chk("t3_hold_req", o_if.req, 1);
      chk("t3_hold_aid", o_if.aid, 1);
      chk("t3_hold_addr", o_if.addr, aa);
      chk("t3_hold_be", o_if.be, 16'hFFFF);
      tick();
    end
    o_if.gnt = 1'b1; settle();
    chk("t3_gnt_aid", o_if.aid, 1);
    tick(); settle();
    chk("t3_next_aid", o_if.aid, 0);
    chk("t3_next_addr", o_if.addr, ab);
    chk("t3_next_be", o_if.be, 16'h0000);
    tick();
    s_if.resp_ready = 1'b0;
    drv_r(1, 1, da); settle();
    chk("t3_a_idle", o_if.req, 0);
    tick();
    drv_r(1, 0, db); settle();
    chk("t3_rv", s_if.resp_valid, 1);
    chk("t3_rid", s_if.resp_id, 1);
    chk("t3_rvd", s_if.resp_vd, da);
    tick();
    for (int k = 0; k < 3; k++) begin
      drv_r(0, 0, '0); settle();
      chk("t3_hold_rv", s_if.resp_valid, 1);
      chk("t3_hold_rid", s_if.resp_id, 1);
      chk("t3_hold_rvd", s_if.resp_vd, da);
      tick();
    end
    s_if.resp_ready = 1'b1; settle();
    chk("t3_rid_final", s_if.resp_id, 1);
    tick(); settle();
    chk("t3_rv2", s_if.resp_valid, 1);
    chk("t3_rid2", s_if.resp_id, 0);
    chk("t3_rvd2_zero", s_if.resp_vd, 0);
    tick(); settle();
    chk("t3_no_dup", s_if.resp_valid, 0);
    tick();

    // ID collision: id 3 busy until its response handshake
    aa = $urandom; ab = $urandom; ia = $urandom_range(0, 16);
    da = rnd_vec(); db = rnd_vec();
    drv_req(1, 3, aa, 8); settle(); tick();
    drv_req(0, 0, 0, 0); settle(); tick();
    drv_req(1, 3, ab, ia); settle();
    chk("t4_blocked_wait", s_if.req_ready, 0);
    tick();
    drv_r(1, 3, da); settle();
    chk("t4_blocked_rv", s_if.req_ready, 0);
    tick();
    drv_r(0, 0, '0); settle();
    chk("t4_rv", s_if.resp_valid, 1);
    chk("t4_rid", s_if.resp_id, 3);
    chk("t4_rvd", s_if.resp_vd, exp_vd(da, 8));
    chk("t4_reaccept", s_if.req_ready, 1);
    tick();
    drv_req(0, 0, 0, 0); settle();
    chk("t4_req2", o_if.req, 1);
    chk("t4_addr2", o_if.addr, ab);
    chk("t4_rv_gone", s_if.resp_valid, 0);
    tick();
    drv_r(1, 3, db); settle(); tick();
    drv_r(0, 0, '0); settle();
    chk("t4_rid2", s_if.resp_id, 3);
    chk("t4_rvd2", s_if.resp_vd, exp_vd(db, ia));
    tick();

    // full scoreboard
    for (int k = 0; k < NumIds; k++) begin
      drv_req(1, IdT'(k), $urandom, 16); settle(); tick();
    end
    drv_req(0, 0, 0, 0); settle(); tick();
    for (int k = 0; k < NumIds; k++) begin
      drv_req(1, IdT'(k), $urandom, 16); settle();
      chk("t5_full", s_if.req_ready, 0);
    end
    da = rnd_vec(); aa = $urandom;
    drv_req(0, 0, 0, 0); drv_r(1, 1, da); settle(); tick();
    drv_r(0, 0, '0); settle();
    chk("t5_rid", s_if.resp_id, 1);
    chk("t5_rvd", s_if.resp_vd, da);
    for (int k = 0; k < NumIds; k++) begin
      drv_req(1, IdT'(k), aa, 16); settle();
      chk("t5_only_freed", s_if.req_ready, k == 1);
    end
    drv_req(1, 1, aa, 16); settle(); tick();
    drv_req(0, 0, 0, 0); settle();
    chk("t5_reissue_aid", o_if.aid, 1);
    chk("t5_reissue_addr", o_if.addr, aa);
    tick();

    // reset with all four loads granted, then late R beats
    rst = 1'b1; settle(); tick();
    rst = 1'b0; settle();
    chk("t6_req_dropped", o_if.req, 0);
    for (int k = 0; k <= NumIds; k++) begin
      if (k < NumIds) drv_r(1, IdT'(k), rnd_vec());
      else drv_r(0, 0, '0);
      settle();
      chk("t6_no_resp", s_if.resp_valid, 0);
      chk("t6_no_req", o_if.req, 0);
      tick();
    end
    aa = $urandom; da = rnd_vec();
    drv_req(1, 0, aa, 12); settle();
    chk("t6_fresh_ready", s_if.req_ready, 1);
    tick();
    drv_req(0, 0, 0, 0); settle();
    chk("t6_fresh_aid", o_if.aid, 0);
    chk("t6_fresh_addr", o_if.addr, aa);
    tick();
    drv_r(1, 0, da); settle(); tick();
    drv_r(0, 0, '0); settle();
    chk("t6_fresh_rv", s_if.resp_valid, 1);
    chk("t6_fresh_vd", s_if.resp_vd, exp_vd(da, 12));
    tick(); settle();
    chk("t6_fresh_done", s_if.resp_valid, 0);
    tick();

    // random traffic against the model
    for (int i = 0; i < NumIds; i++) m_st[i] = M_FREE;
    p_a_stall = 1'b0; p_r_stall = 1'b0; n_resp = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (cyc < 600 && $urandom_range(0, 1) == 1)
        drv_req(1, IdT'($urandom_range(0, NumIds - 1)), $urandom, $urandom_range(0, 20));
      else drv_req(0, 0, 0, 0);
      o_if.gnt        = (cyc >= 600) || ($urandom_range(0, 3) != 0);
      s_if.resp_ready = (cyc >= 600) || ($urandom_range(0, 2) != 0);
      nw = 0;
      for (int i = 0; i < NumIds; i++) if (m_st[i] == M_WAIT) nw++;
      rv_on = 1'b0; rv_id = '0; rv_d = rnd_vec();
      if (nw > 0 && ((cyc >= 600) || $urandom_range(0, 1) == 1)) begin
        sel = $urandom_range(0, nw - 1);
        for (int i = 0; i < NumIds; i++) begin
          if (m_st[i] == M_WAIT) begin
            if (sel == 0) begin rv_on = 1'b1; rv_id = IdT'(i); end
            sel--;
          end
        end
      end
      drv_r(rv_on, rv_id, rv_d);
      settle();

      if (p_a_stall) begin
        chk("r_hold_req", o_if.req, 1);
        chk("r_hold_aid", o_if.aid, h_aid);
        chk("r_hold_addr", o_if.addr, h_addr);
        chk("r_hold_be", o_if.be, h_be);
      end else begin
        chk("r_req", o_if.req, lowest(M_PEND) >= 0);
        if (o_if.req) chk("r_aid_lowest", o_if.aid, lowest(M_PEND));
      end
      if (o_if.req) begin
        chk("r_aid_pend", m_st[o_if.aid], M_PEND);
        chk("r_addr", o_if.addr, m_addr[o_if.aid]);
        chk("r_be", o_if.be, exp_be(m_imm[o_if.aid]));
      end
      if (p_r_stall) begin
        chk("r_hold_rv", s_if.resp_valid, 1);
        chk("r_hold_rid", s_if.resp_id, h_rid);
        chk("r_hold_rvd", s_if.resp_vd, h_vd);
      end else begin
        chk("r_rv", s_if.resp_valid, lowest(M_DONE) >= 0);
        if (s_if.resp_valid) chk("r_rid_lowest", s_if.resp_id, lowest(M_DONE));
      end
      if (s_if.resp_valid) begin
        chk("r_rid_done", m_st[s_if.resp_id], M_DONE);
        chk("r_rvd", s_if.resp_vd, m_data[s_if.resp_id]);
      end
      a_hs = o_if.req && o_if.gnt;
      r_hs = s_if.resp_valid && s_if.resp_ready;
      exp_rdy = s_if.req_valid && (m_st[s_if.req_id] == M_FREE ||
                (r_hs && s_if.resp_id == s_if.req_id && m_st[s_if.req_id] == M_DONE));
      chk("r_ready", s_if.req_ready, exp_rdy);

      if (r_hs) begin m_st[s_if.resp_id] = M_FREE; n_resp++; end
      if (a_hs) m_st[o_if.aid] = M_WAIT;
      if (rv_on) begin
        m_st[rv_id]   = M_DONE;
        m_data[rv_id] = exp_vd(rv_d, m_imm[rv_id]);
      end
      if (exp_rdy) begin
        m_st[s_if.req_id]   = M_PEND;
        m_addr[s_if.req_id] = s_if.req_rs1;
        m_imm[s_if.req_id]  = s_if.req_imm;
      end
      p_a_stall = o_if.req && !o_if.gnt;
      h_aid = o_if.aid; h_addr = o_if.addr; h_be = o_if.be;
      p_r_stall = s_if.resp_valid && !s_if.resp_ready;
      h_rid = s_if.resp_id; h_vd = s_if.resp_vd;
      busy = 0;
      for (int i = 0; i < NumIds; i++) if (m_st[i] != M_FREE) busy++;
      tick();
      if (cyc >= 600 && busy == 0) break;
    end
    chk("r_drained", busy, 0);
    chk("r_traffic", n_resp > 50, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
